snn_memory_port_arbiter: RTL and testbench

//  - Shares the single-port synchronous config/weight memory between two requesters:
//    SPI write path (pulse from SPI control unit write_memory_enable) and SNN core read path (weight/delay fetch).
//  - One-entry write buffer decouples the SPI byte timing from the memory.
//  - Core reads get priority; a bounded-starvation counter forces pending SPI writes through.
//  - Sits between SPI control unit / address regs, the SNN core and the memory macro; single clock domain.

---
 rtl/snn_mem_arb_pkg.sv | 21 ++
 rtl/snn_memory_port_arbiter_spi_write_buffer.sv | 63 ++++++
 rtl/snn_memory_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_snn_memory_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_mem_arb_pkg.sv
// Shared definitions for the SNN memory port arbiter: FSM state encoding and
// default geometry of the config/weight memory port.
package snn_mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_WAIT   = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE     = 2'd0;
    localparam arb_state_t ST_RD_ISSUE = 2'd1;
    localparam arb_state_t ST_RD_WAIT  = 2'd2;
    localparam arb_state_t ST_WR_ISSUE = 2'd3;

    // Width of a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/snn_memory_port_arbiter_spi_write_buffer.sv
// One-entry SPI write buffer: captures a write pulse, releases it on drain, and
// flags any pulse that arrives while the entry is still occupied.
module spi_write_buffer
    import snn_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  drain_i,
    output logic                  full_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  overflow_o
);

    logic                  full_q, full_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  overflow_q, overflow_d;
    logic                  load;

    // The entry being written to memory this cycle frees the slot for a new pulse.
    assign load = wr_req_i && (!full_q || drain_i);

    always_comb begin
        full_d     = full_q;
        addr_d     = addr_q;
        data_d     = data_q;
        overflow_d = overflow_q | (wr_req_i && !load);
        if (load) begin
            full_d = 1'b1;
            addr_d = wr_addr_i;
            data_d = wr_data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign full_o     = full_q;
    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/snn_memory_port_arbiter.sv
// Arbitrates the single-port config/weight memory between SNN core reads and
// buffered SPI writes; reads win until a pending write has waited MAX_WAIT grants.
module snn_memory_port_arbiter
    import snn_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_wr_req,
    input  logic [ADDR_WIDTH-1:0] spi_wr_addr,
    input  logic [DATA_WIDTH-1:0] spi_wr_data,
    output logic                  spi_wr_pending,
    output logic                  spi_wr_overflow,
    input  logic                  core_rd_req,
    input  logic [ADDR_WIDTH-1:0] core_rd_addr,
    output logic                  core_rd_grant,
    output logic                  core_rd_valid,
    output logic [DATA_WIDTH-1:0] core_rd_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int               CNT_W   = cnt_width(MAX_WAIT);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  buf_full;
    logic                  buf_drain;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  write_forced;

    assign buf_drain = (state_q == ST_WR_ISSUE);

    spi_write_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .wr_req_i  (spi_wr_req),
        .wr_addr_i (spi_wr_addr),
        .wr_data_i (spi_wr_data),
        .drain_i   (buf_drain),
        .full_o    (buf_full),
        .addr_o    (buf_addr),
        .data_o    (buf_data),
        .overflow_o(spi_wr_overflow)
    );

    // A write that has sat through MAX_WAIT read grants now beats the core.
    assign write_forced = buf_full && (wait_cnt_q == MAX_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (core_rd_req && !write_forced) begin
                    state_d = ST_RD_ISSUE;
                end else if (buf_full) begin
                    state_d = ST_WR_ISSUE;
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_RD_WAIT:  state_d = ST_IDLE;
            ST_WR_ISSUE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en        = (state_q == ST_RD_ISSUE) || (state_q == ST_WR_ISSUE);
        mem_we        = (state_q == ST_WR_ISSUE);
        core_rd_grant = (state_q == ST_RD_ISSUE);
    end

    // Address/data are loaded on entry to an issue state so the port never
    // depends combinationally on the requesters' inputs.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wait_cnt_d  = wait_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = (state_q == ST_RD_WAIT);
        if (state_q == ST_IDLE && state_d == ST_RD_ISSUE) begin
            mem_addr_d = core_rd_addr;
        end else if (state_q == ST_IDLE && state_d == ST_WR_ISSUE) begin
            mem_addr_d  = buf_addr;
            mem_wdata_d = buf_data;
        end
        if (state_q == ST_RD_ISSUE && buf_full && wait_cnt_q != MAX_CNT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else if (state_q == ST_WR_ISSUE) begin
            wait_cnt_d = '0;
        end
        if (state_q == ST_RD_WAIT) begin
            rd_data_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign spi_wr_pending = buf_full;
    assign core_rd_valid  = rd_valid_q;
    assign core_rd_data   = rd_data_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_snn_memory_port_arbiter.sv
// Self-checking bench: a slot-scheduling reference model predicts every output
// each cycle; directed scenarios pin the model with literal expectations.
module tb_snn_memory_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          spi_wr_req = 1'b0;
    logic [AW-1:0] spi_wr_addr = '0;
    logic [DW-1:0] spi_wr_data = '0;
    logic          spi_wr_pending, spi_wr_overflow;
    logic          core_rd_req = 1'b0;
    logic [AW-1:0] core_rd_addr = '0;
    logic          core_rd_grant, core_rd_valid;
    logic [DW-1:0] core_rd_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    snn_memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(rst),
        .spi_wr_req(spi_wr_req), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
        .spi_wr_pending(spi_wr_pending), .spi_wr_overflow(spi_wr_overflow),
        .core_rd_req(core_rd_req), .core_rd_addr(core_rd_addr),
        .core_rd_grant(core_rd_grant), .core_rd_valid(core_rd_valid), .core_rd_data(core_rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory macro: synchronous single port, read data one cycle after enable.
    logic [7:0] mem_arr [0:65535];
    initial forever begin
        @(posedge clk);
        if (mem_en === 1'b1) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    // Each granted access is placed into a timeline of future cycles.
    logic [7:0] ref_mem [0:65535];
    bit          s_en[8], s_we[8], s_grant[8], s_valid[8];
    logic [15:0] s_addr[8];
    logic [7:0]  s_wdata[8], s_data[8];
    int unsigned cyc = 0, free_at = 0;
    bit          m_full, m_ovf;
    logic [15:0] m_baddr;
    logic [7:0]  m_bdata;
    int          waits;
    bit          e_en, e_we, e_grant, e_valid;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata, e_data;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            s_en[i] = 0; s_we[i] = 0; s_grant[i] = 0; s_valid[i] = 0;
            s_addr[i] = '0; s_wdata[i] = '0; s_data[i] = '0;
        end
        free_at = 0; m_full = 0; m_ovf = 0; m_baddr = '0; m_bdata = '0; waits = 0;
        e_en = 0; e_we = 0; e_grant = 0; e_valid = 0; e_addr = '0; e_wdata = '0; e_data = '0;
    endtask

    task automatic model_step();
        bit drain, did_read;
        int n;
        drain = e_en && e_we;
        if (drain) ref_mem[e_addr] = e_wdata;
        if (e_en && !e_we) s_data[(cyc + 2) % 8] = ref_mem[e_addr];
        did_read = 0;
        if (cyc >= free_at) begin
            n = (cyc + 1) % 8;
            if (core_rd_req && !(m_full && waits == MAXW)) begin
                s_en[n] = 1; s_grant[n] = 1; s_addr[n] = core_rd_addr;
                s_valid[(cyc + 3) % 8] = 1;
                free_at = cyc + 3;
                did_read = 1;
            end else if (m_full) begin
                s_en[n] = 1; s_we[n] = 1; s_addr[n] = m_baddr; s_wdata[n] = m_bdata;
                free_at = cyc + 2;
                waits = 0;
            end
        end
        if (spi_wr_req) begin
            if (!m_full || drain) begin
                m_full = 1; m_baddr = spi_wr_addr; m_bdata = spi_wr_data;
            end else begin
                m_ovf = 1;
            end
        end else if (drain) begin
            m_full = 0;
        end
        if (did_read && m_full && waits < MAXW) waits++;
        cyc++;
        n = cyc % 8;
        e_en = s_en[n]; e_we = s_we[n]; e_grant = s_grant[n]; e_valid = s_valid[n];
        if (s_en[n]) e_addr = s_addr[n];
        if (s_we[n]) e_wdata = s_wdata[n];
        if (s_valid[n]) e_data = s_data[n];
        s_en[n] = 0; s_we[n] = 0; s_grant[n] = 0; s_valid[n] = 0;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_mem_en",   mem_en,          e_en);
            chk("m_mem_we",   mem_we,          e_we);
            chk("m_mem_addr", mem_addr,        e_addr);
            chk("m_wdata",    mem_wdata,       e_wdata);
            chk("m_grant",    core_rd_grant,   e_grant);
            chk("m_valid",    core_rd_valid,   e_valid);
            chk("m_rd_data",  core_rd_data,    e_data);
            chk("m_pending",  spi_wr_pending,  m_full);
            chk("m_overflow", spi_wr_overflow, m_ovf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        core_rd_req = 0; spi_wr_req = 0;
        repeat (n) tick();
    endtask

    task automatic wr_pulse(input logic [15:0] a, input logic [7:0] d);
        spi_wr_req = 1; spi_wr_addr = a; spi_wr_data = d;
    endtask

    // Waits for a grant (bounded), then releases the read request.
    task automatic grant_then_drop(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (core_rd_grant) ok = 1;
        end
        chk(name, ok, 1);
        core_rd_req = 0;
    endtask

    // Holds the read request until a memory write appears (bounded); counts grants.
    task automatic run_until_write(output int grants, output bit seen);
        grants = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            spi_wr_req = 0;
            if (mem_en && mem_we) seen = 1;
            else if (core_rd_grant) begin
                grants++;
                core_rd_addr = 16'($urandom_range(0, 63));
            end
        end
    endtask

    initial begin
        int  grants;
        bit  seen;
        for (int a = 0; a < 65536; a++) begin
            mem_arr[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
            ref_mem[a] = mem_arr[a];
        end
        #1 rst = 1;
        #1 chk_en = 1;
        tick(); tick();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rd_data", core_rd_data, 0);
        chk("rst_pending", spi_wr_pending, 0);
        chk("rst_grant_valid", {core_rd_grant, core_rd_valid}, 0);
        rst = 0;
        idle(2);

        // Single write
        wr_pulse(16'h0102, 8'hA5);
        tick(); spi_wr_req = 0;
        chk("wr_pending", spi_wr_pending, 1);
        chk("wr_not_yet", mem_en, 0);
        tick();
        chk("wr_en_we", {mem_en, mem_we}, 2'b11);
        chk("wr_addr", mem_addr, 16'h0102);
        chk("wr_data", mem_wdata, 8'hA5);
        tick();
        chk("wr_pending_drop", spi_wr_pending, 0);
        chk("wr_mem_content", mem_arr[16'h0102], 8'hA5);
        idle(2);

        // Single read
        mem_arr[16'h0010] = 8'h3C; ref_mem[16'h0010] = 8'h3C;
        core_rd_req = 1; core_rd_addr = 16'h0010;
        tick(); core_rd_req = 0;
        chk("rd_grant", core_rd_grant, 1);
        chk("rd_en_we", {mem_en, mem_we}, 2'b10);
        chk("rd_addr", mem_addr, 16'h0010);
        tick();
        chk("rd_wait_valid", core_rd_valid, 0);
        tick();
        chk("rd_valid", core_rd_valid, 1);
        chk("rd_data", core_rd_data, 8'h3C);
        tick();
        chk("rd_valid_pulse", core_rd_valid, 0);
        chk("rd_data_held", core_rd_data, 8'h3C);
        idle(2);

        // Drain + load in the same cycle
        wr_pulse(16'h0400, 8'h33);
        tick(); spi_wr_req = 0;
        tick();
        chk("dl_first_we", mem_we, 1);
        wr_pulse(16'h0500, 8'h44);
        tick(); spi_wr_req = 0;
        chk("dl_pending", spi_wr_pending, 1);
        chk("dl_no_overflow", spi_wr_overflow, 0);
        tick();
        chk("dl_second_addr", mem_addr, 16'h0500);
        chk("dl_second_data", mem_wdata, 8'h44);
        idle(3);

        // Starvation bound: simultaneous request, read wins, write waits MAXW grants
        core_rd_req = 1; core_rd_addr = 16'h0021;
        wr_pulse(16'h0600, 8'h55);
        run_until_write(grants, seen);
        chk("starve_write_seen", seen, 1);
        chk("starve_grants", grants, MAXW);
        chk("starve_addr", mem_addr, 16'h0600);
        grant_then_drop("starve_reads_resume");
        idle(4);

        // Overflow: second pulse while the buffer is held by reads
        core_rd_req = 1; core_rd_addr = 16'h0030;
        wr_pulse(16'h0200, 8'h11);
        tick();
        wr_pulse(16'h0300, 8'h22);
        tick(); spi_wr_req = 0;
        chk("ovf_set", spi_wr_overflow, 1);
        run_until_write(grants, seen);
        chk("ovf_write_seen", seen, 1);
        chk("ovf_first_addr", mem_addr, 16'h0200);
        chk("ovf_first_data", mem_wdata, 8'h11);
        grant_then_drop("ovf_grant");
        idle(4);
        chk("ovf_sticky", spi_wr_overflow, 1);

        // Reset in the middle of a read issue
        core_rd_req = 1; core_rd_addr = 16'h0040;
        grant_then_drop("rstmid_grant");
        #2 rst = 1;
        #1;
        chk("rstmid_mem_en", mem_en, 0);
        chk("rstmid_grant", core_rd_grant, 0);
        chk("rstmid_overflow", spi_wr_overflow, 0);
        chk("rstmid_rd_data", core_rd_data, 0);
        tick(); rst = 0;
        seen = 0;
        repeat (6) begin
            tick();
            if (core_rd_valid) seen = 1;
        end
        chk("rstmid_no_valid", seen, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            spi_wr_req = ($urandom_range(0, 99) < 15);
            spi_wr_addr = 16'($urandom_range(0, 63));
            spi_wr_data = 8'($urandom);
            if (core_rd_req) begin
                if (core_rd_grant) begin
                    if ($urandom_range(0, 1) == 0) core_rd_req = 0;
                    else core_rd_addr = 16'($urandom_range(0, 63));
                end else if ($urandom_range(0, 99) == 0) begin
                    core_rd_req = 0;
                end
            end else if ($urandom_range(0, 99) < 30) begin
                core_rd_req = 1;
                core_rd_addr = 16'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1;
                tick();
                rst = 0;
            end
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
